// File: rtl/nibble_subt_sequencer.sv
// nibble_subt_sequencer: multi-cycle W-bit subtractor. It drives an external 4-bit
// carry_select_subt slice once per cycle, least-significant nibble first, and chains
// the slice carry between steps.
// Optional feature macro: SUBT_CLAMP_EN. When defined, a borrowing result saturates
// diff to zero.
module nibble_subt_sequencer #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = 4 * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    output logic [3:0]   slice_a_o,
    output logic [3:0]   slice_b_o,
    output logic         slice_cin_o,
    input  logic [3:0]   slice_sum_i,
    input  logic         slice_cout_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned StepW = $clog2(NIBBLES);
    localparam logic [StepW-1:0] LastStep = StepW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;    // working difference, built nibble by nibble
    logic [W-1:0]     diff_q, diff_d;  // presented result, updated only on RUN->DONE
    logic             borrow_q, borrow_d;
    logic             carry_q, carry_d;
    logic [StepW-1:0] step_q, step_d;
    logic [StepW+1:0] nib_base;

    assign nib_base = {step_q, 2'b00};
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

    // Next-state, datapath update and handshake/slice outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        carry_d     = carry_q;
        step_d      = step_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        slice_a_o   = 4'h0;
        slice_b_o   = 4'h0;
        slice_cin_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    step_d  = '0;
                    carry_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                slice_a_o   = a_q[nib_base +: 4];
                slice_b_o   = b_q[nib_base +: 4];
                slice_cin_o = carry_q;
                acc_d[nib_base +: 4] = slice_sum_i;
                carry_d = slice_cout_i;
                if (step_q == LastStep) begin
                    step_d   = '0;
                    state_d  = StDone;
                    diff_d   = acc_d;
                    borrow_d = ~slice_cout_i;
`ifdef SUBT_CLAMP_EN
                    // Saturate: a borrowing subtract reads as zero.
                    if (!slice_cout_i) begin
                        diff_d = '0;
                    end
`else
`endif
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            carry_q  <= 1'b1;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            carry_q  <= carry_d;
            step_q   <= step_d;
        end
    end

endmodule
